// File: rtl/sbox_seq_pkg.sv
// Shared types and constants for the sbox sequencing controller.
package sbox_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned PERF_W   = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/sbox.sv
// Registered 4-bit substitution unit shared by the crypto round datapath.
module sbox
  import sbox_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NIBBLE_W-1:0] i_data,
  output logic [NIBBLE_W-1:0] o_data
);

  logic [NIBBLE_W-1:0] w_sub;
  logic [NIBBLE_W-1:0] r_out;

  always_comb begin
    w_sub = '0;
    unique case (i_data)
      4'h0: w_sub = 4'hF;
      4'h1: w_sub = 4'h3;
      4'h2: w_sub = 4'hE;
      4'h3: w_sub = 4'h0;
      4'h4: w_sub = 4'h8;
      4'h5: w_sub = 4'hB;
      4'h6: w_sub = 4'h1;
      4'h7: w_sub = 4'hD;
      4'h8: w_sub = 4'h6;
      4'h9: w_sub = 4'hA;
      4'hA: w_sub = 4'h2;
      4'hB: w_sub = 4'hC;
      4'hC: w_sub = 4'h5;
      4'hD: w_sub = 4'h9;
      4'hE: w_sub = 4'h7;
      4'hF: w_sub = 4'h4;
      default: w_sub = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_sub;
  end

  assign o_data = r_out;

endmodule

// File: rtl/sbox_seq_arb.sv
// Two-way round-robin arbiter; on a tie the requester other than the last winner is granted.
module sbox_seq_arb
  import sbox_seq_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sbox_seq_ctrl.sv
// Shares one registered sbox between two requesters, streaming words nibble by nibble.
// Define SBOX_SEQ_PERF_EN to add saturating grant and stall counters.
module sbox_seq_ctrl
  import sbox_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req0_data,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req1_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  rsp_data,
  output logic                         rsp_id,
  output logic [NIBBLE_W-1:0]          sbox_data,
  input  logic [NIBBLE_W-1:0]          sbox_out,
  output logic                         busy
`ifdef SBOX_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]            perf_grant0,
  output logic [PERF_W-1:0]            perf_grant1,
  output logic [PERF_W-1:0]            perf_stall
`endif
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                            r_state, w_state_d;
  logic [IDX_W-1:0]                  r_idx;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_word;
  logic [W-1:0]                      r_result;
  req_id_t                           r_id, r_last_grant;
  logic [NIBBLE_W-1:0]               r_sbox_hold;
  logic [NIBBLE_W-1:0]               w_nibble;
  logic [1:0]                        w_grant;
  logic                              w_accept;
  logic [W+NIBBLE_W-1:0]             w_shift;

  sbox_seq_arb u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign req0_ready = (r_state == IDLE) && w_grant[0];
  assign req1_ready = (r_state == IDLE) && w_grant[1];
  assign w_accept   = req0_ready | req1_ready;

  assign w_nibble  = r_word[r_idx];
  assign sbox_data = (r_state == ISSUE) ? w_nibble : r_sbox_hold;
  // Results arrive LSB nibble first, so shift in at the top and down by one nibble.
  assign w_shift   = {sbox_out, r_result};

  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_result;
  assign rsp_id    = r_id;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_d = ISSUE;
      ISSUE:   if (r_idx == LAST_IDX) w_state_d = DRAIN;
      DRAIN:   w_state_d = RESP;
      RESP:    if (rsp_ready) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_word       <= '0;
      r_result     <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_sbox_hold  <= '0;
    end else begin
      if (w_accept) begin
        r_word       <= req1_ready ? req1_data : req0_data;
        r_id         <= req1_ready;
        r_last_grant <= req1_ready;
        r_idx        <= '0;
      end
      if (r_state == ISSUE) begin
        r_sbox_hold <= w_nibble;
        r_idx       <= r_idx + 1'b1;
        if (r_idx != '0) r_result <= w_shift[W+NIBBLE_W-1:NIBBLE_W];
      end
      if (r_state == DRAIN) r_result <= w_shift[W+NIBBLE_W-1:NIBBLE_W];
    end
  end

`ifdef SBOX_SEQ_PERF_EN
  logic [PERF_W-1:0] r_perf_g0, r_perf_g1, r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_g0    <= '0;
      r_perf_g1    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (req0_ready && (r_perf_g0 != '1)) r_perf_g0 <= r_perf_g0 + 1'b1;
      if (req1_ready && (r_perf_g1 != '1)) r_perf_g1 <= r_perf_g1 + 1'b1;
      if ((r_state == RESP) && !rsp_ready && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
    end
  end

  assign perf_grant0 = r_perf_g0;
  assign perf_grant1 = r_perf_g1;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: doc/sbox_seq_ctrl.md
Name: sbox_seq_ctrl

Overview:
Controller that shares one 4-bit substitution unit (the `sbox` module) between two requesters.
- Each requester submits a word of NIBBLES nibbles over a valid/ready handshake.
- The controller arbitrates round-robin between the two requesters.
- It streams the accepted word's nibbles LSB-first through the substitution unit, one per cycle, and reassembles the results.
- It returns the substituted word plus the requester ID on a response valid/ready channel.
- It sits between the crypto-round datapath and the shared `sbox` instance.

Parameters:
- NIBBLES, 4, nibbles per word; word width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req0_data  in  W  requester 0 word.
- req1_valid  in  1  requester 1 has a word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- req1_data  in  W  requester 1 word.
- rsp_valid  out  1  substituted word available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  W  substituted word.
- rsp_id  out  1  requester that owns rsp_data.
- sbox_data  out  4  nibble driven into the substitution unit.
- sbox_out  in  4  unit output; registered; valid one cycle after sbox_data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, sbox_data=0, busy=0, last_grant=1 (so requester 0 wins the first tie), nibble index=0.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - Grant is combinational. If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - reqN_ready = (state==IDLE) && grant==N; at most one ready is high per cycle.
  - On handshake: latch the word and the ID, update last_grant, go to ISSUE.
  - No valid high: stay in IDLE.
- ISSUE, NIBBLES cycles, index k = 0..NIBBLES-1:
  - sbox_data = word[4k+3:4k].
  - From the second ISSUE cycle on, capture sbox_out into result[4(k-1)+3:4(k-1)].
  - After index NIBBLES-1, go to DRAIN.
- DRAIN, 1 cycle: capture the last nibble into result[W-1:W-4], go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid=0 next cycle.
- Latency: request accepted at edge A → rsp_valid high from cycle A+NIBBLES+2. Minimum spacing between accepts is NIBBLES+3 cycles (no request accepted outside IDLE).
- sbox_data outside ISSUE holds its last driven value.
- sbox_out is sampled only in the cycle after an ISSUE cycle; values at all other times are ignored.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset mid-operation: any state returns to IDLE. The in-flight word is discarded and no response is produced. sbox_out garbage during reset is ignored.
- A requester dropping valid while not granted is legal. Data is sampled only at handshake.
- Backpressure: rsp_ready low holds RESP indefinitely; busy stays high; both reqN_ready stay low.

Optional Feature:
SBOX_SEQ_PERF_EN
- Defined: adds outputs perf_grant0 and perf_grant1 (16 bits each).
  - Each counts accepted requests for its requester and saturates at 0xFFFF.
  - Both reset to 0 on rst.
  - Adds output perf_stall (16 bits, saturating), counting cycles in RESP with rsp_ready low.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sbox_seq_pkg:
  - NIBBLE_W=4.
  - State enum type {IDLE, ISSUE, DRAIN, RESP}.
  - Requester-ID typedef (1 bit).
  - Saturating-counter width constant PERF_W=16.
- Sub-module sbox_seq_arb: 2-way round-robin arbiter (valids and last_grant in, one-hot grant out). It is the natural split; the FSM and reassembly stay in the top module.
- The bench instantiates the real `sbox` with its own rst tied to rst and its clk tied to clk.

Test Plan:
- Reset, then req0_valid=1 with req0_data=0x0000 (NIBBLES=4) → rsp_valid at accept+6, rsp_data=0xFFFF, rsp_id=0.
- req1 only, req1_data=0x10F0 → rsp_data=0x3F4F, rsp_id=1; sbox_data sequence 0x0, 0xF, 0x0, 0x1.
- Both valid continuously, req0=0xFFFF and req1=0x0000, rsp_ready=1 → responses alternate id 0/1/0/1 with data 0x4444/0xFFFF.
- rsp_ready held low 10 cycles in RESP → rsp_data and rsp_id stable, both reqN_ready=0, busy=1; release → IDLE next cycle.
- rst pulsed during the second ISSUE cycle → next cycle state=IDLE, rsp_valid=0, busy=0, no response for the aborted word; next request completes correctly.
- SBOX_SEQ_PERF_EN defined, 3 req0 and 2 req1 grants, 4 stall cycles → perf_grant0=3, perf_grant1=2, perf_stall=4.
